led_blink_multi: RTL and testbench

//  - N-channel successor to the single-LED blinker: each channel drives one LED at one of four

---
 rtl/led_blink_multi_pkg.sv | 40 ++++
 rtl/led_blink_channel.sv | 76 +++++++
 rtl/led_blink_multi.sv | 127 ++++++++++++
 tb/tb_led_blink_multi.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/led_blink_multi_pkg.sv
// -----------------------------------------------------------------------------
// led_blink_multi_pkg
//   Shared definitions for the multi-channel LED blinker:
//     - SEL_R0..SEL_R3 : rate-select encodings carried on each channel's sel bits
//     - half_ticks()   : ticks per half-period for one blink rate
//     - clog2_int()    : ceiling log2, used to size counters
//     - max_int()      : helper for sizing from the largest half-period
//   No ports (package).
// -----------------------------------------------------------------------------
package led_blink_multi_pkg;

    localparam logic [1:0] SEL_R0 = 2'b00;
    localparam logic [1:0] SEL_R1 = 2'b01;
    localparam logic [1:0] SEL_R2 = 2'b10;
    localparam logic [1:0] SEL_R3 = 2'b11;

    // A full blink period holds two half-periods, so a rate of R Hz needs a
    // toggle every tick_hz/(2*R) ticks.
    function automatic int half_ticks(input int tick_hz, input int rate_hz);
        return tick_hz / (2 * rate_hz);
    endfunction

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2_int(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_blink_channel.sv
// -----------------------------------------------------------------------------
// led_blink_channel
//   One LED channel of the multi-channel blinker. Counts base ticks up to the
//   half-period of the currently latched rate and toggles the LED at each
//   half-period boundary. The rate select is only re-sampled at a toggle (or
//   while disabled / held in reset / synced), so a rate change never produces
//   a runt pulse.
//
//   Ports
//     clock   in  1       rising-edge clock
//     reset   in  1       synchronous active-high reset
//     tick    in  1       one-cycle base-tick strobe from the shared prescaler
//     enable  in  1       channel enable; low forces the LED off
//     sel     in  2       rate select (SEL_R0..SEL_R3)
//     sync    in  1       phase-align request; same effect as reset on this channel
//     led     out 1       registered LED drive, 1 = on
// -----------------------------------------------------------------------------
module led_blink_channel
    import led_blink_multi_pkg::*;
#(
    parameter int CNT_W = 9,
    parameter int HALF0 = 5,
    parameter int HALF1 = 10,
    parameter int HALF2 = 50,
    parameter int HALF3 = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       enable,
    input  logic [1:0] sel,
    input  logic       sync,
    output logic       led
);

    localparam logic [CNT_W-1:0] LAST0 = CNT_W'(HALF0 - 1);
    localparam logic [CNT_W-1:0] LAST1 = CNT_W'(HALF1 - 1);
    localparam logic [CNT_W-1:0] LAST2 = CNT_W'(HALF2 - 1);
    localparam logic [CNT_W-1:0] LAST3 = CNT_W'(HALF3 - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] cnt_last;

    // Terminal count of the half-period currently in progress.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        cnt_last = LAST0;
        case (sel_q)
            SEL_R0:  cnt_last = LAST0;
            SEL_R1:  cnt_last = LAST1;
            SEL_R2:  cnt_last = LAST2;
            SEL_R3:  cnt_last = LAST3;
            default: cnt_last = LAST0;
        endcase
    end

    // Reset and sync take priority over the enable gate, which in turn takes
    // priority over a tick arriving in the same cycle.
    always_ff @(posedge clock) begin
        if (reset || sync || !enable) begin
            cnt   <= '0;
            led   <= 1'b0;
            sel_q <= sel;
        end else if (tick) begin
            if (cnt == cnt_last) begin
                cnt   <= '0;
                led   <= ~led;
                sel_q <= sel;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_blink_multi.sv
// -----------------------------------------------------------------------------
// led_blink_multi
//   N-channel LED blinker. A shared prescaler divides the fabric clock down to
//   a base tick; each channel counts ticks to one of four half-periods chosen
//   by its 2-bit select, and is gated by its own enable.
//
//   Build option
//     LED_BLINK_SYNC_EN  when defined, adds i_sync: a 1 clears the prescaler,
//                        all channel counters and LEDs on the next edge and
//                        reloads every latched select, phase-aligning the
//                        channels. Priority is reset > sync > enable/tick.
//
//   Ports
//     i_clock      in   1         rising-edge clock
//     i_reset      in   1         synchronous active-high reset
//     i_enable     in   NUM_CH    per-channel enable, bit k -> channel k
//     i_sel        in   2*NUM_CH  rate select, bits [2k+1:2k] -> channel k
//     i_sync       in   1         (LED_BLINK_SYNC_EN only) phase-align strobe
//     o_led_drive  out  NUM_CH    registered LED drive, 1 = on
//     o_tick       out  1         registered one-cycle base-tick strobe
// -----------------------------------------------------------------------------
module led_blink_multi
    import led_blink_multi_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25000,
    parameter int TICK_HZ     = 1000,
    parameter int NUM_CH      = 4,
    parameter int RATE0_HZ    = 100,
    parameter int RATE1_HZ    = 50,
    parameter int RATE2_HZ    = 10,
    parameter int RATE3_HZ    = 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [NUM_CH-1:0]   i_enable,
    input  logic [2*NUM_CH-1:0] i_sel,
`ifdef LED_BLINK_SYNC_EN
    input  logic                i_sync,
`endif
    output logic [NUM_CH-1:0]   o_led_drive,
    output logic                o_tick
);

    localparam int CLK_DIV  = CLK_FREQ_HZ / TICK_HZ;
    localparam int HALF0    = half_ticks(TICK_HZ, RATE0_HZ);
    localparam int HALF1    = half_ticks(TICK_HZ, RATE1_HZ);
    localparam int HALF2    = half_ticks(TICK_HZ, RATE2_HZ);
    localparam int HALF3    = half_ticks(TICK_HZ, RATE3_HZ);
    localparam int MAX_HALF = max_int(max_int(HALF0, HALF1), max_int(HALF2, HALF3));
    localparam int CNT_W    = max_int(1, clog2_int(MAX_HALF));
    localparam int PRE_W    = max_int(1, clog2_int(CLK_DIV));

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("led_blink_multi: NUM_CH=%0d outside 1..16", NUM_CH);
    end
    if ((CLK_FREQ_HZ % TICK_HZ) != 0) begin : g_bad_clk_div
        $error("led_blink_multi: CLK_FREQ_HZ not divisible by TICK_HZ");
    end
    if ((TICK_HZ % (2 * RATE0_HZ)) != 0) begin : g_bad_rate0
        $error("led_blink_multi: TICK_HZ not divisible by 2*RATE0_HZ");
    end
    if ((TICK_HZ % (2 * RATE1_HZ)) != 0) begin : g_bad_rate1
        $error("led_blink_multi: TICK_HZ not divisible by 2*RATE1_HZ");
    end
    if ((TICK_HZ % (2 * RATE2_HZ)) != 0) begin : g_bad_rate2
        $error("led_blink_multi: TICK_HZ not divisible by 2*RATE2_HZ");
    end
    if ((TICK_HZ % (2 * RATE3_HZ)) != 0) begin : g_bad_rate3
        $error("led_blink_multi: TICK_HZ not divisible by 2*RATE3_HZ");
    end

    // -------------------------------------------------------------------------
    // Sync request (constant 0 when the feature is not built in)
    // -------------------------------------------------------------------------
    logic sync;
`ifdef LED_BLINK_SYNC_EN
    assign sync = i_sync;
`else
    assign sync = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Shared prescaler. o_tick is registered from the terminal count, so it is
    // high in the cycle after the count reaches CLK_DIV-1; with the count at 0
    // after reset the first tick appears after the CLK_DIV-th edge.
    // -------------------------------------------------------------------------
    logic [PRE_W-1:0] pre_cnt;

    always_ff @(posedge i_clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (i_reset || sync) begin
            pre_cnt <= '0;
            o_tick  <= 1'b0;
        end else begin
            o_tick  <= (pre_cnt == PRE_LAST);
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Channels
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        led_blink_channel #(
            .CNT_W (CNT_W),
            .HALF0 (HALF0),
            .HALF1 (HALF1),
            .HALF2 (HALF2),
            .HALF3 (HALF3)
        ) u_channel (
            .clock  (i_clock),
            .reset  (i_reset),
            .tick   (o_tick),
            .enable (i_enable[k]),
            .sel    (i_sel[2*k +: 2]),
            .sync   (sync),
            .led    (o_led_drive[k])
        );
    end

endmodule

// File: tb/tb_led_blink_multi.sv
// -----------------------------------------------------------------------------
// tb_led_blink_multi
//   Directed bench for led_blink_multi at default parameters (25 kHz clock,
//   1 kHz tick, half-periods of 125/250/1250/12500 clock cycles).
//   Timeline reference: "edge n" counts rising edges after the state in which
//   reset (or sync) was last applied; a channel toggles on edge 25*HALF*m + 1.
// -----------------------------------------------------------------------------
module tb_led_blink_multi;

    localparam int NUM_CH = 4;

    logic                i_clock = 1'b0;
    logic                i_reset;
    logic [NUM_CH-1:0]   i_enable;
    logic [2*NUM_CH-1:0] i_sel;
`ifdef LED_BLINK_SYNC_EN
    logic                i_sync;
`endif
    logic [NUM_CH-1:0]   o_led_drive;
    logic                o_tick;

    int vectors     = 0;
    int miscompares = 0;

    always #5 i_clock = ~i_clock;

    led_blink_multi #(
        .CLK_FREQ_HZ (25000),
        .TICK_HZ     (1000),
        .NUM_CH      (NUM_CH),
        .RATE0_HZ    (100),
        .RATE1_HZ    (50),
        .RATE2_HZ    (10),
        .RATE3_HZ    (1)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_sel       (i_sel),
`ifdef LED_BLINK_SYNC_EN
        .i_sync      (i_sync),
`endif
        .o_led_drive (o_led_drive),
        .o_tick      (o_tick)
    );

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge i_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Step until the watched output (idx<0: o_tick, else o_led_drive[idx])
    // equals val; n returns edges taken, or budget+1 if it never happened.
    task automatic wait_for(input int idx, input logic val, input int budget, output int n);
        logic s;
        n = 0;
        while (n < budget) begin
            step(1);
            n++;
            s = (idx < 0) ? o_tick : o_led_drive[idx];
            if (s === val) return;
        end
        n = budget + 1;
    endtask

    initial begin
        int          n;
        int          bad;
        int          tog [NUM_CH];
        logic [NUM_CH-1:0] prev;

        i_reset  = 1'b1;
        i_enable = '1;
        i_sel    = '0;
`ifdef LED_BLINK_SYNC_EN
        i_sync   = 1'b0;
`endif

        // 1. Reset held 3 cycles with everything enabled.
        for (int c = 0; c < 3; c++) begin
            step(1);
            check("rst_led", 32'(o_led_drive), 32'd0);
            check("rst_tick", 32'(o_tick), 32'd0);
        end
        i_reset = 1'b0;
        wait_for(-1, 1'b1, 40, n);
        check("first_tick_edge", n, 25);
        step(1);
        check("tick_one_cycle", 32'(o_tick), 32'd0);

        // 2. ch0 at sel=00: first on at edge 126, then every 125 edges.
        wait_for(0, 1'b1, 200, n);
        check("r0_first_on", n, 100);
        wait_for(0, 1'b0, 200, n);
        check("r0_off", n, 125);
        wait_for(0, 1'b1, 200, n);
        check("r0_on", n, 125);

        // 3. Four rates over 25001 edges: toggles at 125/250/1250/12500*m + 1.
        i_sel   = {2'b11, 2'b10, 2'b01, 2'b00};
        i_reset = 1'b1;
        step(1);
        check("rst2_led", 32'(o_led_drive), 32'd0);
        i_reset = 1'b0;
        prev = o_led_drive;
        for (int k = 0; k < NUM_CH; k++) tog[k] = 0;
        for (int c = 0; c < 25001; c++) begin
            step(1);
            for (int k = 0; k < NUM_CH; k++)
                if (o_led_drive[k] !== prev[k]) tog[k]++;
            prev = o_led_drive;
        end
        check("toggles_100hz", tog[0], 200);
        check("toggles_50hz", tog[1], 100);
        check("toggles_10hz", tog[2], 20);
        check("toggles_1hz", tog[3], 2);
        check("toggles_end_state", 32'(o_led_drive), 32'd0);

        // 4. ch1 at sel=11, switched to 00 at edge 3000: old half finishes at 12501.
        i_sel   = 8'h0C;
        i_reset = 1'b1;
        step(1);
        i_reset = 1'b0;
        step(3000);
        check("r3_still_off", 32'(o_led_drive[1]), 32'd0);
        i_sel = 8'h00;
        wait_for(1, 1'b1, 12000, n);
        check("r3_finishes_old_rate", n, 9501);
        wait_for(1, 1'b0, 200, n);
        check("new_rate_off", n, 125);
        wait_for(1, 1'b1, 200, n);
        check("new_rate_on", n, 125);

        // 5. ch1 now on (edge 12751); next tick shows after edge 12775.
        wait_for(-1, 1'b1, 30, n);
        check("tick_before_drop", n, 24);
        check("led1_on_before_drop", 32'(o_led_drive[1]), 32'd1);
        i_enable = 4'b1101;
        step(1);
        check("disable_in_tick_cycle", 32'(o_led_drive[1]), 32'd0);
        bad = 0;
        for (int c = 0; c < 299; c++) begin
            step(1);
            if (o_led_drive[1] !== 1'b0) bad++;
        end
        check("disabled_stays_off", bad, 0);
        // 300 edges after a tick edge is again a tick cycle.
        check("tick_at_reenable", 32'(o_tick), 32'd1);
        i_enable = '1;
        wait_for(1, 1'b1, 200, n);
        check("reenable_first_on", n, 101);

`ifdef LED_BLINK_SYNC_EN
        // 6. Sync with channels out of phase, then reset together with sync.
        i_sel  = 8'h00;
        i_sync = 1'b1;
        step(1);
        i_sync = 1'b0;
        check("sync_leds_off", 32'(o_led_drive), 32'd0);
        wait_for(0, 1'b1, 200, n);
        check("sync_first_on", n, 126);
        check("sync_aligned", 32'(o_led_drive), 32'hF);
        i_reset = 1'b1;
        i_sync  = 1'b1;
        step(1);
        check("rst_sync_leds", 32'(o_led_drive), 32'd0);
        check("rst_sync_tick", 32'(o_tick), 32'd0);
        i_reset = 1'b0;
        i_sync  = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
